md_unit: RTL
============

Name: md_unit

Overview:
- Iterative multiply/divide responder in the EX stage.
- Consumes the EX-stage MD control fields (MDFunc, MDSign, MDHIWB, MDLOWB) plus operands.
- Owns the architectural HI/LO registers.
- Raises busy so the hazard logic stalls MD-dependent instructions.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  EX instruction carries a valid MD operation this cycle
MDFunc  input  3  000 none, 001 multiply, 010 divide, others reserved (treated as none)
MDSign  input  1  1 = signed operation, 0 = unsigned
MDHIWB  input  1  write HI from A (mthi)
MDLOWB  input  1  write LO from A (mtlo)
flush  input  1  EX_FLUSH; aborts any in-flight operation
A  input  WIDTH  rs operand: multiplicand or dividend
B  input  WIDTH  rt operand: multiplier or divisor
HI  output  WIDTH  HI register: product high half or remainder
LO  output  WIDTH  LO register: product low half or quotient
busy  output  1  operation in flight

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, HI=0, LO=0, busy=0, counter=0. Asserting reset mid-operation discards the operation.
- States: IDLE, RUN, FIX.
- IDLE transitions, evaluated each edge in this priority order:
  1. flush=1: no action.
  2. MDHIWB / MDLOWB: write A into HI / LO (both may write in the same cycle). start is ignored that cycle.
  3. start=1 with MDFunc=001 or 010: latch the operation and go to RUN.
  4. start with MDFunc none or reserved: no action.
- Latching an operation:
  - Store the sign flags of A and B when MDSign=1; otherwise the signs are 0.
  - Load the working registers with magnitudes |A| and |B|. |-2^(WIDTH-1)| is taken as an unsigned 2^(WIDTH-1).
  - Load counter=WIDTH.
- RUN: one iteration per cycle, counter decrements, go to FIX after the WIDTH-th iteration.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring divide.
- FIX:
  - Apply signs: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
  - Write HI/LO and return to IDLE.
- Latency and busy:
  - start is sampled at edge E0, HI/LO update at edge E(WIDTH+1) (E33 for the default).
  - busy=1 from after E0 until E(WIDTH+1), i.e. WIDTH+1 cycles, and drops on the same edge HI/LO update.
  - HI/LO hold their old values throughout the operation.
- Divide by zero: same latency; result is LO = all ones, HI = A, independent of MDSign.
- Signed overflow (-2^(WIDTH-1) / -1): LO = 0x80000000, HI = 0. This falls out of the magnitude/sign scheme with no special case.
- flush while in RUN or FIX: return to IDLE at the next edge, busy=0, HI/LO unchanged. A flush in the FIX cycle wins over the write.
- start, MDHIWB and MDLOWB while busy=1 are ignored. The controller is required to stall; a bench assertion flags any violation.
- HI and LO are direct register outputs with no combinational bypass. Reads in the same cycle as a write see the old value.

Test Plan:
- Signed multiply: A=0xFFFFFFFD (-3), B=7, MDSign=1 -> after 33 busy cycles, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Unsigned multiply: A=B=0xFFFFFFFF, MDSign=0 -> HI=0xFFFFFFFE, LO=0x00000001. The signed variant gives HI=0, LO=1.
- Signed divide: A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Unsigned A=100, B=7 -> LO=14, HI=2. A=0x80000000, B=0xFFFFFFFF signed -> LO=0x80000000, HI=0.
- Divide by zero: A=0x12345678, B=0 -> LO=0xFFFFFFFF, HI=0x12345678, busy exactly 33 cycles.
- mthi/mtlo: MDHIWB=MDLOWB=1, A=0xCAFEBABE, start=1 same cycle -> HI=LO=0xCAFEBABE next edge, busy stays 0. mthi while busy -> HI unchanged.
- Abort paths:
  - Start a divide with HI=0x11, LO=0x22.
  - flush at cycle 10 -> busy=0 next edge, HI=0x11, LO=0x22.
  - Repeat with reset at cycle 20 -> HI=LO=0, busy=0 immediately.
  - A new multiply issued right after the flush completes correctly.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit that owns the architectural HI/LO registers.
// Shift-add multiply and restoring divide work on operand magnitudes; signs are applied in FIX.
module md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDFunc,
  input  logic             MDSign,
  input  logic             MDHIWB,
  input  logic             MDLOWB,
  input  logic             flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic load, hi_wr, lo_wr, fix_wr, op_valid;
  logic a_neg, b_neg;

  logic is_div, s_a, s_b, b_zero;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_bit;
  logic [WIDTH-1:0] div_rem;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v,
                                                         input logic neg);
    return neg ? -v : v;
  endfunction

  assign op_valid = start && (MDFunc == 3'b001 || MDFunc == 3'b010);
  assign a_neg    = MDSign & A[WIDTH-1];
  assign b_neg    = MDSign & B[WIDTH-1];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load)
        cnt <= CNT_W'(WIDTH);
      else if (flush)
        cnt <= '0;
      else if (state == RUN && cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    hi_wr     = 1'b0;
    lo_wr     = 1'b0;
    fix_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (!flush) begin
          if (MDHIWB || MDLOWB) begin
            hi_wr = MDHIWB;
            lo_wr = MDLOWB;
          end else if (op_valid) begin
            load      = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (flush)
          state_nxt = IDLE;
        else if (cnt == CNT_W'(1))
          state_nxt = FIX;
      end
      FIX: begin
        state_nxt = IDLE;
        fix_wr    = !flush;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration per cycle: multiply adds the multiplicand then shifts right,
  // divide shifts the next dividend bit into the remainder and tries to subtract.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_bit   = (div_shift >= {1'b0, opnd});
  assign div_sub   = div_shift[WIDTH-1:0] - opnd;
  assign div_rem   = div_bit ? div_sub : div_shift[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (load) begin
      is_div <= (MDFunc == 3'b010);
      s_a    <= a_neg;
      s_b    <= b_neg;
      b_zero <= (B == '0);
      acc_hi <= '0;
      if (MDFunc == 3'b010) begin
        opnd   <= apply_sign(B, b_neg);
        acc_lo <= apply_sign(A, a_neg);
      end else begin
        opnd   <= apply_sign(A, a_neg);
        acc_lo <= apply_sign(B, b_neg);
      end
    end else if (state == RUN) begin
      if (is_div) begin
        acc_hi <= div_rem;
        acc_lo <= {acc_lo[WIDTH-2:0], div_bit};
      end else begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  // Architectural HI/LO: mthi/mtlo writes in IDLE, signed result write in FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else begin
      if (hi_wr)
        HI <= A;
      if (lo_wr)
        LO <= A;
      if (fix_wr) begin
        if (is_div) begin
          HI <= apply_sign(acc_hi, s_a);
          LO <= b_zero ? '1 : apply_sign(acc_lo, s_a ^ s_b);
        end else begin
          {HI, LO} <= apply_sign_wide({acc_hi, acc_lo}, s_a ^ s_b);
        end
      end
    end
  end

endmodule
